// File: rtl/func_sweep_checker.sv
// func_sweep_checker: drives all 16 vectors {w,x,y,z} into the NAND-NAND and
// NOR-NOR realizations of F = w'z' + y'z' + wx', samples both responses after
// a settle window and scores them against a golden truth table.
module func_sweep_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] GOLDEN        = 16'h1F55
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        fnand,
   input  logic        fnor,
   output logic        w,
   output logic        x,
   output logic        y,
   output logic        z,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic        first_fail_valid,
   output logic [3:0]  first_fail_idx,
   output logic [15:0] nand_sig,
   output logic [15:0] nor_sig
);

   // The settle counter runs from SETTLE_CYCLES-1 down to 0, so a vector is
   // held for SETTLE_CYCLES cycles plus the one SAMPLE cycle.
   localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [4:0]  r_errCount;
   logic        r_ffValid;
   logic [3:0]  r_ffIdx;
   logic [15:0] r_nandSig;
   logic [15:0] r_norSig;

   logic        w_golden;
   logic        w_fail;
   logic [4:0]  w_errNext;

   // The vector index is itself the stimulus register; w is its MSB.
   assign {w, x, y, z}     = r_idx;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_errCount;
   assign first_fail_valid = r_ffValid;
   assign first_fail_idx   = r_ffIdx;
   assign nand_sig         = r_nandSig;
   assign nor_sig          = r_norSig;

   assign w_golden = GOLDEN[r_idx];

   // A vector fails unless both responses provably equal the golden bit; an
   // unknown comparison falls through to the failing default.
   always_comb begin
      w_fail = 1'b1;
      if ((fnand == w_golden) && (fnor == w_golden)) begin
         w_fail = 1'b0;
      end
   end

   // Error count as it will stand after the current sample is scored.
   assign w_errNext = r_errCount + {4'd0, w_fail};

   // Sweep sequencer: state, stimulus index, settle counter and all results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= 4'd0;
         r_cnt      <= 4'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_errCount <= 5'd0;
         r_ffValid  <= 1'b0;
         r_ffIdx    <= 4'd0;
         r_nandSig  <= 16'd0;
         r_norSig   <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state    <= ST_SETTLE;
                  r_idx      <= 4'd0;
                  r_cnt      <= LP_RELOAD;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  r_errCount <= 5'd0;
                  r_ffValid  <= 1'b0;
                  r_ffIdx    <= 4'd0;
                  r_nandSig  <= 16'd0;
                  r_norSig   <= 16'd0;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_SAMPLE: begin
               r_nandSig[r_idx] <= fnand;
               r_norSig[r_idx]  <= fnor;
               if (w_fail) begin
                  r_errCount <= w_errNext;
                  if (!r_ffValid) begin
                     r_ffValid <= 1'b1;
                     r_ffIdx   <= r_idx;
                  end
               end
               if (r_idx == 4'd15) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_errNext == 5'd0);
               end else begin
                  r_state <= ST_SETTLE;
                  r_idx   <= r_idx + 4'd1;
                  r_cnt   <= LP_RELOAD;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/func_sweep_checker.md
# func_sweep_checker

Self-checking sweep stage for the 4-input function F = w'z' + y'z' + wx'. It sits upstream of the two-level NAND and NOR realizations of F, driving all 16 input vectors {w,x,y,z} in ascending order. It also sits downstream of them, sampling FNAND and FNOR after a programmable settle time and comparing both against a golden truth table. It reports pass/fail, the mismatch count, the first failing vector and the captured response signatures.

## Interface

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range 1..15.
- GOLDEN, 16'h1F55: expected F per vector; bit i is the expected value for {w,x,y,z} = i.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  sweep request; sampled only in IDLE and DONE.
- fnand  input  1  FNAND output of the NAND-NAND realization.
- fnor  input  1  FNOR output of the NOR-NOR realization.
- w, x, y, z  output  1 each  registered stimulus to both realizations; w is the MSB of the vector index.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high while in DONE; results are valid.
- pass  output  1  high in DONE when err_count == 0; otherwise 0.
- err_count  output  5  number of failing vectors, 0..16.
- first_fail_valid  output  1  a failure has been recorded in this sweep.
- first_fail_idx  output  4  index of the first failing vector; 0 when first_fail_valid = 0.
- nand_sig  output  16  bit i holds fnand as sampled at vector i.
- nor_sig  output  16  bit i holds fnor as sampled at vector i.

## Operation

- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: set idx=0 and drive {w,x,y,z}=0000. Clear err_count, first_fail_*, nand_sig and nor_sig. Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement the counter. When the counter is 0, go to SAMPLE.
- SAMPLE (exactly 1 cycle): write fnand into nand_sig[idx] and fnor into nor_sig[idx].
- A vector fails if fnand != GOLDEN[idx] or fnor != GOLDEN[idx]. Each failing vector increments err_count by 1, even when both outputs are wrong.
- On the first failure of a sweep: set first_fail_valid=1 and first_fail_idx=idx.
- After SAMPLE: if idx==15, go to DONE and keep driving vector 1111. Otherwise set idx=idx+1, drive the new vector, reload the counter and go to SETTLE.
- DONE: hold all results. start=1 restarts exactly as from IDLE, clearing the results on the same edge. start=0 stays in DONE.
- start is ignored in SETTLE and SAMPLE.
- An X/Z value on fnand/fnor at sample time counts as a mismatch (simulation semantics).
- The idx register is 4 bits and never wraps: the transition at 15 always goes to DONE.

## Timing

- Reset values (sampled on the edge with rst_n=0, from any state including mid-sweep): state IDLE, {w,x,y,z}=0000, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0, nand_sig=0, nor_sig=0.
- Reset dominates start on the same edge.
- Let E0 be the edge that accepts start. At E0, vector 0 appears and busy=1.
- Each vector is held for SETTLE_CYCLES+1 cycles. The sample is taken on the last edge of that window, and the next vector appears on the same edge.
- done and pass rise, and busy falls, on edge E0 + 16×(SETTLE_CYCLES+1). For the default settings this is E0+48.
- err_count, first_fail_* and the signatures update on the sampling edge of their vector and are stable in DONE.
- The DUT path is combinational. Each vector therefore has SETTLE_CYCLES full cycles plus the SAMPLE cycle to propagate.

## Test plan

- Correct realizations, SETTLE_CYCLES=2, single start pulse:
  - done rises at E0+48.
  - pass=1, err_count=0, first_fail_valid=0.
  - nand_sig = nor_sig = 16'h1F55.
  - The stimulus visits 0000..1111 in order, with 3 cycles per vector.
- fnor stuck at 0:
  - err_count=9, first_fail_idx=0, first_fail_valid=1, pass=0.
  - nor_sig=16'h0000, nand_sig=16'h1F55.
- fnand forced to 1 only when the vector is 1101:
  - err_count=1, first_fail_idx=13.
  - nand_sig=16'h3F55, pass=0.
- fnand inverted and fnor inverted simultaneously:
  - err_count=16 (one per vector, not 32), first_fail_idx=0.
  - nand_sig = nor_sig = 16'hE0AA.
- rst_n low for one edge while vector 7 is driven:
  - Every output matches the reset values on the next cycle.
  - A following start produces a clean full sweep with pass=1.
- start held high throughout:
  - It is ignored while busy.
  - It is accepted on the cycle after done rises, clearing the results on that edge.
  - The second sweep completes 48 cycles later with identical results.
  - SETTLE_CYCLES=1 variant: done at E0+32.
